// File: rtl/generic_serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface generic_serial_subtractor_if #(
  parameter int A_WIDTH = 28,
  parameter int B_WIDTH = 28
);
  localparam int D_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;

  logic signed [A_WIDTH-1:0] A;
  logic signed [B_WIDTH-1:0] B;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [D_WIDTH-1:0] diff;
  logic                      zero;
  logic                      neg;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output A, B, in_valid, out_ready,
    input  in_ready, diff, zero, neg, out_valid
  );

  modport slave (
    input  A, B, in_valid, out_ready,
    output in_ready, diff, zero, neg, out_valid
  );
endinterface

// File: rtl/generic_serial_subtractor.sv
// Serial signed subtractor: computes A - B one CHUNK-bit slice per cycle, LSB slice first,
// rippling the borrow between slices. The result is one bit wider than the widest operand,
// so the difference is always exact.
module generic_serial_subtractor #(
  parameter int A_WIDTH = 28,
  parameter int B_WIDTH = 28,
  parameter int CHUNK   = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  generic_serial_subtractor_if.slave  bus
);

  localparam int D_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;
  localparam int NCHUNK  = (D_WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [D_WIDTH-1:0]   a_q;
  logic [D_WIDTH-1:0]   b_q;
  logic [D_WIDTH-1:0]   diff_q;
  logic                 borrow_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 zero_q;
  logic                 neg_q;

  int                   shamt;
  logic [CHUNK-1:0]     slice_a;
  logic [CHUNK-1:0]     slice_b;
  logic [CHUNK:0]       slice_full;
  logic [D_WIDTH-1:0]   slice_mask;
  logic [D_WIDTH-1:0]   diff_next;
  logic                 last_slice;

  // Slice datapath: pick the current slice of both operands, subtract with the incoming
  // borrow, and merge the result into diff. Bits of the last slice that fall above the
  // result width shift out of range and are dropped, so only the remaining bits are written.
  always_comb begin
    shamt      = int'(idx_q) * CHUNK;
    slice_a    = CHUNK'(a_q >> shamt);
    slice_b    = CHUNK'(b_q >> shamt);
    slice_full = {1'b0, slice_a} - {1'b0, slice_b} - (CHUNK+1)'(borrow_q);
    slice_mask = D_WIDTH'({CHUNK{1'b1}}) << shamt;
    diff_next  = (diff_q & ~slice_mask) | (D_WIDTH'(slice_full[CHUNK-1:0]) << shamt);
    last_slice = (idx_q == IDX_W'(NCHUNK - 1));
  end

  // State register; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake/result outputs. Operands are only looked at in IDLE,
  // and out_ready only matters in DONE, so consume and accept can never share an edge.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.diff      = diff_q;
    bus.zero      = zero_q;
    bus.neg       = neg_q;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (last_slice) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, slice accumulation and flag generation. The flags are computed from
  // the fully assembled result on the final slice edge, so they are valid on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q      <= {{(D_WIDTH-A_WIDTH){bus.A[A_WIDTH-1]}}, bus.A};
            b_q      <= {{(D_WIDTH-B_WIDTH){bus.B[B_WIDTH-1]}}, bus.B};
            diff_q   <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
          end
        end
        CALC: begin
          diff_q   <= diff_next;
          borrow_q <= slice_full[CHUNK];
          if (last_slice) begin
            idx_q  <= '0;
            zero_q <= (diff_next == '0);
            neg_q  <= diff_next[D_WIDTH-1];
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
